uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Serial receiver that consumes the UART TX line (start, 8 data LSB-first, optional parity, stop).
//  Oversamples the line at Prescale x baud, majority-votes each bit, checks parity/stop, and emits
//  the recovered byte with a one-cycle data_valid pulse. Sits directly downstream of the UART TX top.
// PARAMETERS
//  DATA_WIDTH   8   data bits per frame
//  PRESCALE_W   6   width of Prescale input (supports 8, 16, 32)
// PORTS
//  CLK           in   1           oversampling clock (Prescale x baud)
//  RST           in   1           asynchronous, active-high reset
//  RX_IN         in   1           serial line, idle high
//  parity_EN     in   1           1 = frame carries parity bit
//  parity_type   in   1           0 = even, 1 = odd
//  Prescale      in   PRESCALE_W  clocks per bit: 8, 16 or 32
//  P_DATA        out  DATA_WIDTH  received byte
//  data_valid    out  1           1-cycle pulse: P_DATA valid, frame error-free
//  parity_error  out  1           parity mismatch on last frame
//  stop_error    out  1           stop bit sampled low on last frame
// BEHAVIOUR
//  - Reset: P_DATA=0, data_valid=0, parity_error=0, stop_error=0, FSM=IDLE, counters=0, sync flops=1.
//  - RX_IN passes a 2-flop synchronizer (reset 1); all timing below is on synchronized rx_s.
//  - parity_EN, parity_type, Prescale latched on IDLE->START; changes mid-frame ignored.
//  - edge_cnt counts 0..Prescale-1 per bit; bit_cnt counts data bits 0..DATA_WIDTH-1.
//  - Sample: rx_s captured at edge_cnt = P/2-1, P/2, P/2+1; bit value = majority of 3, valid from P/2+2.
//  - FSM:
//    IDLE   : rx_s==0 -> START (edge_cnt=0); clear parity_error, stop_error.
//    START  : at edge_cnt==P-1: sampled bit 0 -> DATA; sampled 1 (glitch) -> IDLE, no outputs.
//    DATA   : shift sampled bit into shift reg LSB-first; after bit DATA_WIDTH-1 at edge_cnt==P-1
//             -> PARITY if parity_EN else STOP.
//    PARITY : at P-1 compare sampled bit with ^data (even) / ~^data (odd); mismatch sets parity_error. -> STOP.
//    STOP   : at P-1 sampled 0 sets stop_error. -> DONE.
//    DONE   : 1 cycle. If no error: P_DATA<=shift reg, data_valid=1 this cycle. -> IDLE.
//  - P_DATA updated only on error-free frames; holds previous value otherwise.
//  - Errors are level outputs held until next start detection (or reset).
//  - Latency: data_valid rises 1 cycle after last clock of stop bit (+2 cycles synchronizer vs RX_IN).
//  - Back-to-back frames: DONE->IDLE costs 1 cycle; next start edge still detected (<=1 cycle skew).
//  - Line held low after stop_error: IDLE re-enters START immediately; resulting frame judged normally.
//  - RST mid-frame: immediate abort to reset values; no partial data_valid.
//  - Prescale outside {8,16,32}: behaviour undefined, not checked.
// STRUCTURE
//  - Shared include uart_rx_defs.vh: FSM state encodings (IDLE..DONE), DATA_WIDTH default,
//    PARITY_EVEN=0/PARITY_ODD=1 (same encoding the TX parity unit uses).
//  - Sub-module uart_rx_sampler: edge_cnt + 3-sample majority, outputs sampled_bit and bit_end strobe.
//  - Top: synchronizer, FSM, bit_cnt, shift reg, parity/stop check, output regs.
// TESTING
//  1 Prescale=8, parity off, frame 0xA5 -> P_DATA=0xA5, data_valid 1 cycle, both errors 0.
//  2 Prescale=16, parity even, 0x3C, parity bit 0 -> 0x3C valid; same frame with parity bit 1
//    -> parity_error=1, data_valid=0, P_DATA keeps 0x3C from prior frame.
//  3 Prescale=32, odd parity, 0x01 with stop bit driven 0 -> stop_error=1, no data_valid.
//  4 RX_IN low for 3 clocks then high (Prescale=16) -> return to IDLE, no outputs, errors unchanged 0.
//  5 Single-clock glitch at P/2 of data bit 3 of 0xF0 -> majority rejects it, 0xF0 received.
//  6 Back-to-back 0x00,0xFF at Prescale=8; RST pulsed mid 2nd frame -> 1st valid, then all outputs 0.
//  - Bench drives RX_IN from the TX top where possible; checks each data_valid against scoreboard.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types, defaults and helpers for the UART receiver
// Contents:
//   DATA_WIDTH_DEF / PRESCALE_W_DEF  default frame and prescale widths
//   PARITY_EVEN / PARITY_ODD         parity_type encoding (matches the TX parity unit)
//   rx_state_t                       receiver FSM states
//   majority3                        2-of-3 vote used on the mid-bit samples
package uart_rx_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESCALE_W_DEF = 6;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit oversample counter with 3-sample majority vote
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   enable       counting enabled (receiver inside a frame); low holds edge_cnt at 0
//   rx           synchronized serial line
//   prescale     clocks per bit (8, 16 or 32), latched by the caller
//   sampled_bit  majority of the samples taken at P/2-1, P/2, P/2+1
//   bit_end      strobe on the last clock of the bit (edge_cnt == P-1)
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  rx,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  bit_end
);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] half;
  logic [2:0]            samples;

  assign half = prescale >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      samples  <= 3'b111;
    end else if (!enable) begin
      edge_cnt <= '0;
    end else begin
      if (edge_cnt == prescale - 1'b1) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + 1'b1;
      end
      if (edge_cnt == half - 1'b1) samples[0] <= rx;
      if (edge_cnt == half)        samples[1] <= rx;
      if (edge_cnt == half + 1'b1) samples[2] <= rx;
    end
  end

  assign bit_end     = enable && (edge_cnt == prescale - 1'b1);
  assign sampled_bit = majority3(samples[0], samples[1], samples[2]);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver (start, LSB-first data, optional parity, stop)
// Ports:
//   CLK           oversampling clock (Prescale x baud)
//   RST           asynchronous active-high reset
//   RX_IN         serial line, idle high
//   parity_EN     frame carries a parity bit (latched at start detection)
//   parity_type   0 = even, 1 = odd (latched at start detection)
//   Prescale      clocks per bit: 8, 16 or 32 (latched at start detection)
//   P_DATA        last error-free received byte
//   data_valid    one-cycle pulse while P_DATA carries a fresh byte
//   parity_error  parity mismatch on the last frame, held until next start
//   stop_error    stop bit sampled low on the last frame, held until next start
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  parity_EN,
  input  logic                  parity_type,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  rx_state_t             state, next_state;
  logic                  rx_meta, rx_s;
  logic                  par_en_q, par_type_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  sampled_bit, bit_end;
  logic                  sampler_en, start_det, exp_parity;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  assign sampler_en = (state == ST_START) || (state == ST_DATA) ||
                      (state == ST_PARITY) || (state == ST_STOP);
  assign start_det  = (state == ST_IDLE) && !rx_s;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk         (CLK),
    .rst         (RST),
    .enable      (sampler_en),
    .rx          (rx_s),
    .prescale    (prescale_q),
    .sampled_bit (sampled_bit),
    .bit_end     (bit_end)
  );

  // The data bits are complete in shift_reg by the time the parity bit ends.
  assign exp_parity = (par_type_q == PARITY_ODD) ? ~^shift_reg : ^shift_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (!rx_s) next_state = ST_START;
      // A start bit that votes high was a glitch: drop back without any outputs.
      ST_START:  if (bit_end) next_state = sampled_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_end && bit_cnt == LAST_BIT)
                   next_state = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) next_state = ST_STOP;
      ST_STOP:   if (bit_end) next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_en_q     <= 1'b0;
      par_type_q   <= PARITY_EVEN;
      prescale_q   <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (start_det) begin
        par_en_q     <= parity_EN;
        par_type_q   <= parity_type;
        prescale_q   <= Prescale;
        bit_cnt      <= '0;
        parity_error <= 1'b0;
        stop_error   <= 1'b0;
      end
      if (state == ST_DATA && bit_end) begin
        shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
        bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end
      if (state == ST_PARITY && bit_end && sampled_bit != exp_parity) begin
        parity_error <= 1'b1;
      end
      // Outputs are registered at the end of the stop bit so that data_valid
      // and the new P_DATA appear together during the DONE cycle.
      if (state == ST_STOP && bit_end) begin
        if (!sampled_bit) begin
          stop_error <= 1'b1;
        end else if (!parity_error) begin
          P_DATA     <= shift_reg;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule
